// File: rtl/fec_pkg.sv
// Shared constants and trellis helpers for the WiMAX rate-1/2 K=7 tail-biting
// convolutional code, used by both the encoder and the Viterbi decoder.
package fec_pkg;
    localparam int BLOCK_BITS = 96;
    localparam int PM_W       = 8;
    localparam int NUM_STATES = 64;
    localparam int CNT_W      = $clog2(BLOCK_BITS);

    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b1011011;

    typedef enum logic [1:0] {
        IN    = 2'd0,
        TRACE = 2'd1,
        OUT   = 2'd2
    } dec_state_t;

    // Coded pair {X, Y} emitted for input u from state s
    function automatic logic [1:0] expected_xy(input logic u, input logic [5:0] s);
        return {^({u, s} & G1), ^({u, s} & G2)};
    endfunction
endpackage

// File: rtl/fec_acs_unit.sv
// Add-compare-select for one trellis state; ties keep the b=0 predecessor.
module fec_acs_unit
    import fec_pkg::*;
(
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            surv
);
    logic [PM_W-1:0] sum0;
    logic [PM_W-1:0] sum1;

    assign sum0   = pm0 + PM_W'(bm0);
    assign sum1   = pm1 + PM_W'(bm1);
    assign surv   = (sum1 < sum0);
    assign pm_new = surv ? sum1 : sum0;
endmodule

// File: rtl/fec_viterbi_decoder.sv
// Hard-decision 64-state Viterbi decoder for one tail-biting block: serial
// coded bits in, full ACS per received pair, traceback, serial data bits out.
module fec_viterbi_decoder
    import fec_pkg::*;
(
    input  logic            clock_50,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    output logic            out_last,
    output logic [PM_W-1:0] out_metric
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BITS - 1);

    dec_state_t            state;
    logic                  have_x;
    logic                  x_lat;
    logic [CNT_W-1:0]      step;
    logic [CNT_W-1:0]      idx;
    logic [5:0]            trace_n;
    logic [PM_W-1:0]       pm     [NUM_STATES];
    logic [PM_W-1:0]       pm_nxt [NUM_STATES];
    logic [NUM_STATES-1:0] surv_nxt;
    logic [NUM_STATES-1:0] surv_mem [BLOCK_BITS];
    logic [BLOCK_BITS-1:0] obuf;
    logic [PM_W-1:0]       best_pm;
    logic [5:0]            best_state;
    logic [5:0]            n_cur;
    logic [1:0]            rx_xy;
    logic                  pair_done;

    function automatic logic [1:0] hd2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

    assign in_ready  = (state == IN);
    assign out_valid = (state == OUT);
    assign out_data  = out_valid & obuf[idx];
    assign out_last  = out_valid && (idx == LAST);
    assign rx_xy     = {x_lat, in_data};
    assign pair_done = in_ready && in_valid && have_x;

    generate
        for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
            localparam logic [5:0] NS = 6'(n);
            localparam logic [5:0] P0 = {NS[4:0], 1'b0};
            localparam logic [5:0] P1 = {NS[4:0], 1'b1};
            fec_acs_unit u_acs (
                .pm0    (pm[P0]),
                .pm1    (pm[P1]),
                .bm0    (hd2(expected_xy(NS[5], P0), rx_xy)),
                .bm1    (hd2(expected_xy(NS[5], P1), rx_xy)),
                .pm_new (pm_nxt[n]),
                .surv   (surv_nxt[n])
            );
        end
    endgenerate

    always_comb begin
        best_pm    = pm[0];
        best_state = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm[i] < best_pm) begin
                best_pm    = pm[i];
                best_state = 6'(i);
            end
        end
    end

    // step counts down from LAST during traceback, so LAST marks the first cycle
    assign n_cur = (step == LAST) ? best_state : trace_n;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state      <= IN;
            have_x     <= 1'b0;
            x_lat      <= 1'b0;
            step       <= '0;
            idx        <= '0;
            trace_n    <= '0;
            out_metric <= '0;
            for (int i = 0; i < NUM_STATES; i++) pm[i] <= '0;
        end else begin
            case (state)
                IN: begin
                    if (in_valid) begin
                        if (!have_x) begin
                            x_lat  <= in_data;
                            have_x <= 1'b1;
                        end else begin
                            have_x <= 1'b0;
                            for (int i = 0; i < NUM_STATES; i++) pm[i] <= pm_nxt[i];
                            if (step == LAST) state <= TRACE;
                            else              step  <= step + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    trace_n <= {n_cur[4:0], surv_mem[step][n_cur]};
                    if (step == LAST) out_metric <= best_pm;
                    if (step == '0) begin
                        state <= OUT;
                        idx   <= '0;
                    end else begin
                        step <= step - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            state  <= IN;
                            step   <= '0;
                            idx    <= '0;
                            have_x <= 1'b0;
                            for (int i = 0; i < NUM_STATES; i++) pm[i] <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IN;
            endcase
        end
    end

    // Survivor rows and decoded bits are fully rewritten every block
    always_ff @(posedge clock_50) begin
        if (pair_done)        surv_mem[step] <= surv_nxt;
        if (state == TRACE)   obuf[step]     <= n_cur[5];
    end
endmodule

// File: tb/tb_fec_viterbi_decoder.sv
// Scoreboard bench for fec_viterbi_decoder: directed data blocks, injected
// coded-bit errors, flow-control gaps and reset aborts.
module tb_fec_viterbi_decoder;
    logic       clock_50 = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_data;
    logic       out_last;
    logic [7:0] out_metric;

    typedef struct packed {
        logic       data;
        logic       last;
        logic [7:0] metric;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rdy_mode = 1'b0;
    bit   chk_ready_next = 1'b0;

    fec_viterbi_decoder dut (
        .clock_50   (clock_50),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_metric (out_metric)
    );

    always #10 clock_50 = ~clock_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Golden tail-biting encoder: start state holds the last six data bits
    function automatic logic [191:0] encode(input logic [95:0] d);
        logic [5:0]   s;
        logic [6:0]   r;
        logic [191:0] c;
        s = {d[95], d[94], d[93], d[92], d[91], d[90]};
        for (int t = 0; t < 96; t++) begin
            r          = {d[t], s};
            c[2*t]     = ^(r & 7'b1111001);
            c[2*t+1]   = ^(r & 7'b1011011);
            s          = {d[t], s[5:1]};
        end
        return c;
    endfunction

    function automatic logic [95:0] lfsr_data(input logic [15:0] seed);
        logic [15:0] l;
        logic [95:0] d;
        l = seed;
        for (int i = 0; i < 96; i++) begin
            d[i] = l[0];
            l    = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        return d;
    endfunction

    task automatic send_bit(input logic b, input int gap);
        int tmo;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock_50); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        tmo = 0;
        while (!in_ready && tmo < 1000) begin
            @(posedge clock_50); #1;
            tmo++;
        end
        if (tmo >= 1000) check("in_ready_timeout", 32'(tmo), 0);
        @(posedge clock_50); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [95:0] d, input logic [191:0] flip,
                             input int exp_metric, input bit gaps);
        logic [191:0] c;
        int cyc;
        bit rdy_bad;
        c = encode(d) ^ flip;
        for (int i = 0; i < 96; i++) sb.push_back('{d[i], (i == 95), 8'(exp_metric)});
        for (int i = 0; i < 192; i++)
            send_bit(c[i], gaps ? int'($urandom_range(0, 2)) : 0);
        cyc = 0;
        rdy_bad = 1'b0;
        while (!out_valid && cyc < 300) begin
            @(posedge clock_50); #1;
            cyc++;
            if (in_ready) rdy_bad = 1'b1;
        end
        check("out_valid_latency", 32'(cyc), 96);
        check("in_ready_low_in_trace", 32'(rdy_bad), 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clock_50); #1;
            t++;
        end
        check("scoreboard_drained", 32'(sb.size()), 0);
        repeat (2) @(posedge clock_50);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   1);
        check({tag, "_out_valid"},  32'(out_valid),  0);
        check({tag, "_out_data"},   32'(out_data),   0);
        check({tag, "_out_last"},   32'(out_last),   0);
        check({tag, "_out_metric"}, 32'(out_metric), 0);
    endtask

    initial begin
        forever begin
            @(posedge clock_50); #1;
            out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops an expectation on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_50);
            if (chk_ready_next) begin
                check("in_ready_after_last", 32'(in_ready), 1);
                chk_ready_next = 1'b0;
            end
            if (out_valid) begin
                check("in_ready_low_in_out", 32'(in_ready), 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: data %0d with empty scoreboard", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data",   32'(out_data),   32'(e.data));
                        check("out_last",   32'(out_last),   32'(e.last));
                        check("out_metric", 32'(out_metric), 32'(e.metric));
                        if (out_last) chk_ready_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [95:0]  d;
        logic [95:0]  d2;
        logic [191:0] c;
        logic [191:0] flip;
        int t;

        repeat (3) @(posedge clock_50);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        @(posedge clock_50); #1;
        check_reset_vals("post_reset");

        run_block('0, '0, 0, 1'b0);
        drain();
        run_block('1, '0, 0, 1'b0);
        drain();

        d = lfsr_data(16'hACE1);
        run_block(d, '0, 0, 1'b0);
        drain();
        flip = '0; flip[100] = 1'b1;
        run_block(d, flip, 1, 1'b0);
        drain();
        flip = '0; flip[20] = 1'b1; flip[150] = 1'b1;
        run_block(d, flip, 2, 1'b0);
        drain();

        run_block(lfsr_data(16'h1234), '0, 0, 1'b0);
        run_block(lfsr_data(16'hBEEF), '0, 0, 1'b0);
        run_block(lfsr_data(16'h5A5A), '0, 0, 1'b0);
        drain();

        rdy_mode = 1'b1;
        run_block(d, '0, 0, 1'b1);
        flip = '0; flip[100] = 1'b1;
        run_block(d, flip, 1, 1'b1);
        drain();
        rdy_mode = 1'b0;

        // Abort after 70 coded bits of a block
        d2 = lfsr_data(16'h0F0F);
        c = encode(d2);
        for (int i = 0; i < 70; i++) send_bit(c[i], 0);
        reset = 1'b0;
        #2;
        check_reset_vals("mid_in_reset");
        @(posedge clock_50); #1;
        reset = 1'b1;
        run_block(d2, '0, 0, 1'b0);
        drain();

        // Abort part-way through the output phase of an errored block
        rdy_mode = 1'b1;
        flip = '0; flip[7] = 1'b1;
        run_block(d, flip, 1, 1'b0);
        t = 0;
        while (sb.size() > 50 && t < 2000) begin
            @(posedge clock_50); #1;
            t++;
        end
        reset = 1'b0;
        sb.delete();
        #2;
        check_reset_vals("mid_out_reset");
        @(posedge clock_50); #1;
        reset = 1'b1;
        rdy_mode = 1'b0;
        run_block(d2, '0, 0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
